// File: rtl/wb_hex_pkg.sv
// rtl/wb_hex_pkg.sv - shared segment constants and hex glyph table for the writeback monitor
package wb_hex_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low gfedcba glyphs; b and d are lower-case so they stay distinct from 8 and 0.
    function automatic seg_t hex_glyph(input logic [3:0] nib);
        seg_t g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex7_decode.sv
// rtl/hex7_decode.sv - one nibble to active-low seven-segment glyph
module hex7_decode
    import wb_hex_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex_glyph(nib);

endmodule

// File: rtl/wb_hex_monitor.sv
// rtl/wb_hex_monitor.sv - writeback history monitor with hex displays (optional WB_HEX_LZB_EN leading-zero blanking)
module wb_hex_monitor
    import wb_hex_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    parameter  int SCAN_W = 16,
    localparam int NDIG   = DATA_W / 4,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                WB_EN,
    input  logic [2:0]          WB_DR,
    input  logic [DATA_W-1:0]   WB_VAL,
    input  logic                FREEZE,
    input  logic                SEL_STEP,
    output logic [NDIG*7-1:0]   HEX_FLAT,
    output logic [6:0]          HEX_SEG,
    output logic [NDIG-1:0]     HEX_AN,
    output logic [2:0]          DR_OUT,
    output logic [PTR_W-1:0]    VIEW_OFS,
    output logic [PTR_W:0]      HIST_CNT
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef struct packed {
        logic [2:0]        dr;
        logic [DATA_W-1:0] val;
    } entry_t;

    entry_t              mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic                sel_q;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic [IDX_W-1:0]    idx_d;

    logic                capture;
    logic                step_edge;
    entry_t              shown;
    logic                shown_empty;
    logic [NDIG*7-1:0]   glyphs;
    logic [NDIG*7-1:0]   flat_d;

    assign capture   = WB_EN & ~FREEZE;
    assign step_edge = FREEZE & SEL_STEP & ~sel_q;

    // Entry to display next: a fresh commit bypasses the array so it shows one cycle later.
    always_comb begin
        shown       = mem[wr_ptr - PTR_W'(1) - VIEW_OFS];
        shown_empty = (HIST_CNT == '0);
        if (capture) begin
            shown       = '{dr: WB_DR, val: WB_VAL};
            shown_empty = 1'b0;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        hex7_decode u_dec (
            .nib (shown.val[4*g +: 4]),
            .seg (glyphs[7*g +: 7])
        );
    end

    // Per-digit segment pattern: dashes when empty, otherwise glyphs (optionally blanked above the top nonzero digit).
    always_comb begin
        flat_d = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (shown_empty) begin
                flat_d[7*i +: 7] = SEG_DASH;
            end else begin
                flat_d[7*i +: 7] = glyphs[7*i +: 7];
`ifdef WB_HEX_LZB_EN
                if (i > 0 && (shown.val >> (4*i)) == '0)
                    flat_d[7*i +: 7] = SEG_BLANK;
`endif
            end
        end
    end

    // Next scanned digit: advance once per prescaler wrap.
    always_comb begin
        idx_d = scan_idx;
        if (&scan_cnt)
            idx_d = (scan_idx == IDX_W'(NDIG - 1)) ? '0 : scan_idx + IDX_W'(1);
    end

    // History array storage; contents need no reset because HIST_CNT gates their use.
    always_ff @(posedge CLK) begin
        if (!RESET && capture)
            mem[wr_ptr] <= '{dr: WB_DR, val: WB_VAL};
    end

    // Write pointer and saturating fill count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr   <= '0;
            HIST_CNT <= '0;
        end else if (capture) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (HIST_CNT != (PTR_W+1)'(DEPTH))
                HIST_CNT <= HIST_CNT + (PTR_W+1)'(1);
        end
    end

    // Browse offset: held at newest while live, steps older on each SEL_STEP rise while frozen.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sel_q    <= 1'b0;
            VIEW_OFS <= '0;
        end else begin
            sel_q <= SEL_STEP;
            if (!FREEZE)
                VIEW_OFS <= '0;
            else if (step_edge) begin
                if (HIST_CNT == '0 || ({1'b0, VIEW_OFS} + (PTR_W+1)'(1)) >= HIST_CNT)
                    VIEW_OFS <= '0;
                else
                    VIEW_OFS <= VIEW_OFS + PTR_W'(1);
            end
        end
    end

    // Registered parallel display and destination register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HEX_FLAT <= {NDIG{SEG_DASH}};
            DR_OUT   <= '0;
        end else begin
            HEX_FLAT <= flat_d;
            DR_OUT   <= shown_empty ? 3'd0 : shown.dr;
        end
    end

    // Scanned output: segment and anode registered from the same next-state values so they never skew.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            HEX_AN   <= ~NDIG'(1);
            HEX_SEG  <= SEG_DASH;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
            scan_idx <= idx_d;
            HEX_AN   <= ~(NDIG'(1) << idx_d);
            HEX_SEG  <= flat_d[7*idx_d +: 7];
        end
    end

endmodule

// File: tb/tb_wb_hex_monitor.sv
// tb/tb_wb_hex_monitor.sv - scoreboard bench for wb_hex_monitor against a history-queue model
module tb_wb_hex_monitor;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int SCAN_W = 2;
    localparam int NDIG   = 4;

    logic        clk = 1'b0;
    logic        reset, wb_en, freeze, sel_step;
    logic [2:0]  wb_dr;
    logic [15:0] wb_val;
    logic [27:0] hex_flat;
    logic [6:0]  hex_seg;
    logic [3:0]  hex_an;
    logic [2:0]  dr_out;
    logic [1:0]  view_ofs;
    logic [2:0]  hist_cnt;

    always #5 clk = ~clk;

    wb_hex_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SCAN_W(SCAN_W)) dut (
        .CLK      (clk),
        .RESET    (reset),
        .WB_EN    (wb_en),
        .WB_DR    (wb_dr),
        .WB_VAL   (wb_val),
        .FREEZE   (freeze),
        .SEL_STEP (sel_step),
        .HEX_FLAT (hex_flat),
        .HEX_SEG  (hex_seg),
        .HEX_AN   (hex_an),
        .DR_OUT   (dr_out),
        .VIEW_OFS (view_ofs),
        .HIST_CNT (hist_cnt)
    );

    typedef struct {
        logic [27:0] flat;
        logic [2:0]  dr;
        logic [1:0]  view;
        logic [2:0]  cnt;
        logic [3:0]  an;
        logic [6:0]  seg;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [6:0]  glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [18:0] hist[$];
    int          m_view = 0;
    logic        m_sel_prev = 1'b0;
    int          m_k = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [27:0] model_flat(input logic [15:0] v);
        logic [27:0] f;
        logic [3:0]  nib;
        f = '0;
        for (int i = 0; i < NDIG; i++) begin
            nib = v[4*i +: 4];
            f[7*i +: 7] = glyph_tab[nib];
`ifdef WB_HEX_LZB_EN
            if (i > 0 && (v >> (4*i)) == 16'd0)
                f[7*i +: 7] = 7'h7F;
`endif
        end
        return f;
    endfunction

    task automatic cycle(input logic rst, input logic en, input logic [2:0] dr,
                         input logic [15:0] val, input logic frz, input logic sel);
        exp_t        e;
        logic [18:0] ent;
        int          digit;
        @(negedge clk);
        reset = rst; wb_en = en; wb_dr = dr; wb_val = val; freeze = frz; sel_step = sel;
        if (rst) begin
            hist.delete();
            m_view = 0;
            m_sel_prev = 1'b0;
            m_k = 0;
            e.flat = {4{7'h3F}};
            e.dr   = 3'd0;
        end else begin
            if (en && !frz) begin
                hist.push_front({dr, val});
                if (hist.size() > DEPTH) void'(hist.pop_back());
                e.flat = model_flat(val);
                e.dr   = dr;
            end else if (hist.size() == 0) begin
                e.flat = {4{7'h3F}};
                e.dr   = 3'd0;
            end else begin
                ent    = hist[m_view];
                e.flat = model_flat(ent[15:0]);
                e.dr   = ent[18:16];
            end
            if (!frz)
                m_view = 0;
            else if (sel && !m_sel_prev)
                m_view = (hist.size() == 0) ? 0 : (m_view + 1) % hist.size();
            m_sel_prev = sel;
            m_k++;
        end
        e.view = 2'(m_view);
        e.cnt  = 3'(hist.size());
        digit  = (m_k >> SCAN_W) % NDIG;
        e.an   = ~(4'b0001 << digit);
        e.seg  = e.flat[7*digit +: 7];
        exp_q.push_back(e);
    endtask

    // Monitor: every post-edge sample is compared with the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("hex_flat", 32'(hex_flat), 32'(e.flat));
                check("dr_out",   32'(dr_out),   32'(e.dr));
                check("view_ofs", 32'(view_ofs), 32'(e.view));
                check("hist_cnt", 32'(hist_cnt), 32'(e.cnt));
                check("hex_an",   32'(hex_an),   32'(e.an));
                check("hex_seg",  32'(hex_seg),  32'(e.seg));
            end
        end
    end

    initial begin
        logic frz_r;
        logic [15:0] v;
        reset = 1'b1; wb_en = 1'b0; wb_dr = '0; wb_val = '0; freeze = 1'b0; sel_step = 1'b0;

        repeat (3) cycle(1, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        check("reset_an", 32'(hex_an), 32'h0000000E);
        check("reset_flat", 32'(hex_flat), 32'(28'h7EFDFBF));
        check("reset_cnt", 32'(hist_cnt), 32'd0);

        repeat (2) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 3'd3, 16'h12AB, 0, 0);
        @(posedge clk); #2;
        check("t2_flat", 32'(hex_flat), 32'(28'b1111001_0100100_0001000_0000011));
        check("t2_dr", 32'(dr_out), 32'd3);

        for (int i = 1; i <= 5; i++) cycle(0, 1, 3'(i), 16'(i), 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        for (int s = 0; s < 4; s++) begin
            cycle(0, 0, 0, 0, 1, 1);
            cycle(0, 0, 0, 0, 1, 1);
            cycle(0, 0, 0, 0, 1, 0);
        end

        cycle(0, 1, 3'd7, 16'h9999, 1, 0);
        cycle(0, 0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        cycle(1, 0, 0, 0, 0, 0);
        repeat (14) cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        repeat (9) cycle(0, 0, 0, 0, 0, 0);

        cycle(0, 1, 3'd2, 16'h0030, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 3'd1, 16'h0000, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        frz_r = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) frz_r = ~frz_r;
            v = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            cycle($urandom_range(0, 299) == 0, 1'($urandom), 3'($urandom), v,
                  frz_r, 1'($urandom));
        end
        cycle(0, 0, 0, 0, 0, 0);

        @(posedge clk); #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
